// File: rtl/shift_mix_columns.sv
// shift_mix_columns: AES ShiftRows then MixColumns (MixColumns skipped for final-round blocks).
// Latency: 2 cycles; stage 1 registers ShiftRows, stage 2 registers MixColumns.
// Backpressure: valid/ready; holds up to 2 blocks, ready_out follows ready_in once both stages are full.
module shift_mix_columns #(
   parameter int TAG_W         = 4,
   parameter bit LAST_ROUND_EN = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [127:0]       state_in,
   input  logic               shiftmix_valid_in,
   output logic               shiftmix_ready_out,
   input  logic               last_round_in,
   input  logic [TAG_W-1:0]   tag_in,
   output logic [127:0]       state_out,
   output logic               shiftmix_valid_out,
   input  logic               shiftmix_ready_in,
   output logic               last_round_out,
   output logic [TAG_W-1:0]   tag_out
);

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
   endfunction

   // Byte k sits at row k%4, column k/4; row r rotates left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int k = 0; k < 16; k++) begin
         o[127-8*k -: 8] = s[127-8*(4*(((k/4)+(k%4))%4)+(k%4)) -: 8];
      end
      return o;
   endfunction

   // One column, row 0 in the most significant byte.
   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] b0, b1, b2, b3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
      return {b0, b1, b2, b3};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
      end
      return o;
   endfunction

   logic               s1_valid_q, s1_valid_d;
   logic [127:0]       s1_data_q, s1_data_d;
   logic               s1_last_q, s1_last_d;
   logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
   logic               s2_valid_q, s2_valid_d;
   logic [127:0]       s2_data_q, s2_data_d;
   logic               s2_last_q, s2_last_d;
   logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;

   logic               adv2;
   logic               in_xfer;
   logic [127:0]       s2_func;

   // Handshake: s1 moves on when s2 is empty or draining; input accepted when s1 is empty or moving.
   always_comb begin
      adv2               = s1_valid_q & (~s2_valid_q | shiftmix_ready_in);
      shiftmix_ready_out = ~s1_valid_q | adv2;
      in_xfer            = shiftmix_valid_in & shiftmix_ready_out;
      s2_func            = (LAST_ROUND_EN && s1_last_q) ? s1_data_q : mix_columns(s1_data_q);
   end

   // Next-state for both stages; data registers only change on a load.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_last_d  = s1_last_q;
      s1_tag_d   = s1_tag_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_last_d  = s2_last_q;
      s2_tag_d   = s2_tag_q;
      if (in_xfer) begin
         s1_valid_d = 1'b1;
         s1_data_d  = shift_rows(state_in);
         s1_last_d  = last_round_in;
         s1_tag_d   = tag_in;
      end else if (adv2) begin
         s1_valid_d = 1'b0;
      end
      if (adv2) begin
         s2_valid_d = 1'b1;
         s2_data_d  = s2_func;
         s2_last_d  = s1_last_q;
         s2_tag_d   = s1_tag_q;
      end else if (shiftmix_ready_in) begin
         s2_valid_d = 1'b0;
      end
   end

   // Pipeline registers; reset discards in-flight blocks and clears the data.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_last_q  <= 1'b0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_last_q  <= 1'b0;
         s2_tag_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_last_q  <= s1_last_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_last_q  <= s2_last_d;
         s2_tag_q   <= s2_tag_d;
      end
   end

   assign state_out          = s2_data_q;
   assign shiftmix_valid_out = s2_valid_q;
   assign last_round_out     = s2_last_q;
   assign tag_out            = s2_tag_q;

endmodule

// File: tb/tb_shift_mix_columns.sv
// tb_shift_mix_columns: directed and random checks of shift_mix_columns against a matrix-level AES model.
// Latency: model expects each block on the output 2 cycles after acceptance, later only under stall.
// Backpressure: model tracks pipeline occupancy to predict ready_out every cycle.
module tb_shift_mix_columns;

   localparam logic [127:0] APPB     = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] APPB_MIX = 128'h046681e5e0cb199a48f8d37a2806264c;
   localparam logic [127:0] APPB_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

   logic          clk = 1'b0;
   logic          reset;
   logic [127:0]  state_in;
   logic          valid_in;
   logic          last_in;
   logic [3:0]    tag_in;
   logic          ready_in;

   logic          ready_a, valid_a, last_a;
   logic [127:0]  state_a;
   logic [3:0]    tag_a;
   logic          ready_b, valid_b, last_b;
   logic [127:0]  state_b;
   logic [3:0]    tag_b;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int vcount = 0;
   bit mon_en = 1'b0;

   typedef struct {
      logic [127:0] da;
      logic [127:0] db;
      logic         last;
      logic [3:0]   tag;
      int           t;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   shift_mix_columns #(.TAG_W(4), .LAST_ROUND_EN(1'b1)) dut_a (
      .clk(clk), .reset(reset), .state_in(state_in), .shiftmix_valid_in(valid_in),
      .shiftmix_ready_out(ready_a), .last_round_in(last_in), .tag_in(tag_in),
      .state_out(state_a), .shiftmix_valid_out(valid_a), .shiftmix_ready_in(ready_in),
      .last_round_out(last_a), .tag_out(tag_a)
   );

   shift_mix_columns #(.TAG_W(4), .LAST_ROUND_EN(1'b0)) dut_b (
      .clk(clk), .reset(reset), .state_in(state_in), .shiftmix_valid_in(valid_in),
      .shiftmix_ready_out(ready_b), .last_round_in(last_in), .tag_in(tag_in),
      .state_out(state_b), .shiftmix_valid_out(valid_b), .shiftmix_ready_in(ready_in),
      .last_round_out(last_b), .tag_out(tag_b)
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Carry-less polynomial product reduced modulo 0x11B.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] coef(input int d);
      case (d)
         0: return 8'd2;
         1: return 8'd3;
         default: return 8'd1;
      endcase
   endfunction

   // State as a 4x4 byte matrix: rotate rows, then multiply by the circulant MixColumns matrix.
   function automatic logic [127:0] model(input logic [127:0] in, input bit mix);
      logic [7:0]   s[4][4];
      logic [7:0]   t[4][4];
      logic [7:0]   m[4][4];
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) s[r][c] = in[127-8*(4*c+r) -: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) t[r][c] = s[r][(c+r)%4];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            m[r][c] = 8'h00;
            for (int j = 0; j < 4; j++) m[r][c] = m[r][c] ^ gmul(coef((j - r + 4) % 4), t[j][c]);
         end
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = mix ? m[r][c] : t[r][c];
      return o;
   endfunction

   // Per-cycle compare against the model queue, then advance the model.
   always @(negedge clk) begin
      if (mon_en) begin
         bit vexp;
         bit rexp;
         vexp = (q.size() > 0) && (cyc >= q[0].t + 2);
         rexp = (q.size() < 2) || ready_in;
         chk("valid_out_a", valid_a, vexp);
         chk("valid_out_b", valid_b, vexp);
         chk("ready_out_a", ready_a, rexp);
         chk("ready_out_b", ready_b, rexp);
         if (vexp) begin
            vcount++;
            chk("state_out_a", state_a, q[0].da);
            chk("state_out_b", state_b, q[0].db);
            chk("last_out_a", last_a, q[0].last);
            chk("last_out_b", last_b, q[0].last);
            chk("tag_out_a", tag_a, q[0].tag);
            chk("tag_out_b", tag_b, q[0].tag);
         end
         if (reset) begin
            q.delete();
         end else begin
            exp_t e;
            if (vexp && ready_in) void'(q.pop_front());
            if (valid_in && rexp) begin
               e.da   = model(state_in, !last_in);
               e.db   = model(state_in, 1'b1);
               e.last = last_in;
               e.tag  = tag_in;
               e.t    = cyc;
               q.push_back(e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_one(input logic [127:0] d, input logic l, input logic [3:0] t);
      state_in = d; last_in = l; tag_in = t; valid_in = 1'b1;
      step();
      valid_in = 1'b0;
   endtask

   initial begin
      logic [127:0] held;
      int sent;
      bit pending;
      bit acc;
      reset = 1'b1; state_in = '0; valid_in = 1'b0; last_in = 1'b0; tag_in = '0; ready_in = 1'b1;
      repeat (3) step();
      reset = 1'b0;

      // Reset state and model pinning.
      @(negedge clk);
      chk("rst_valid", valid_a, 1'b0);
      chk("rst_state", state_a, '0);
      chk("rst_last", last_a, 1'b0);
      chk("rst_tag", tag_a, '0);
      chk("rst_ready", ready_a, 1'b1);
      chk("model_mix", model(APPB, 1'b1), APPB_MIX);
      chk("model_sr", model(APPB, 1'b0), APPB_SR);
      mon_en = 1'b1;
      step();

      // FIPS-197 round 1.
      send_one(APPB, 1'b0, 4'd3);
      step();
      @(negedge clk);
      chk("r1_valid", valid_a, 1'b1);
      chk("r1_state", state_a, APPB_MIX);
      chk("r1_tag", tag_a, 4'd3);
      step(); step();

      // Final round: bypass on dut_a, MixColumns forced on dut_b.
      send_one(APPB, 1'b1, 4'd5);
      step();
      @(negedge clk);
      chk("lr_state_a", state_a, APPB_SR);
      chk("lr_last_a", last_a, 1'b1);
      chk("lr_state_b", state_b, APPB_MIX);
      chk("lr_tag_b", tag_b, 4'd5);
      step(); step();

      // Streaming: 8 back-to-back blocks.
      vcount = 0;
      for (int i = 0; i < 8; i++) begin
         state_in = {$urandom, $urandom, $urandom, $urandom};
         last_in = i[0]; tag_in = 4'(i); valid_in = 1'b1;
         @(negedge clk);
         chk("stream_ready", ready_a, 1'b1);
         step();
      end
      valid_in = 1'b0;
      repeat (4) step();
      chk("stream_count", vcount, 8);

      // Backpressure: three blocks offered while ready_in is low.
      ready_in = 1'b0;
      send_one(APPB, 1'b0, 4'd8);
      send_one(~APPB, 1'b1, 4'd9);
      state_in = APPB ^ 128'h1; last_in = 1'b0; tag_in = 4'd10; valid_in = 1'b1;
      @(negedge clk);
      chk("bp_ready_low", ready_a, 1'b0);
      held = state_a;
      repeat (3) step();
      @(negedge clk);
      chk("bp_stable", state_a, held);
      chk("bp_held_tag", tag_a, 4'd8);
      ready_in = 1'b1;
      #1;
      chk("bp_ready_follow", ready_a, 1'b1);
      step();
      valid_in = 1'b0;
      @(negedge clk);
      chk("bp_order2", tag_a, 4'd9);
      step();
      @(negedge clk);
      chk("bp_order3", tag_a, 4'd10);
      repeat (3) step();

      // Reset while stalled with a full pipeline.
      ready_in = 1'b0;
      send_one(APPB, 1'b0, 4'd11);
      send_one(~APPB, 1'b0, 4'd12);
      state_in = APPB; tag_in = 4'd13; valid_in = 1'b1; reset = 1'b1;
      step();
      reset = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
      @(negedge clk);
      chk("mrst_valid", valid_a, 1'b0);
      chk("mrst_state", state_a, '0);
      chk("mrst_ready", ready_a, 1'b1);
      chk("mrst_tag", tag_a, '0);
      repeat (5) step();

      // Random traffic; valid held with stable data until accepted.
      sent = 0;
      pending = 1'b0;
      for (int it = 0; it < 60000 && sent < 10000; it++) begin
         if (!pending) begin
            if ($urandom_range(0, 3) != 0) begin
               state_in = {$urandom, $urandom, $urandom, $urandom};
               last_in  = ($urandom_range(0, 3) == 0);
               tag_in   = 4'($urandom);
               valid_in = 1'b1;
               pending  = 1'b1;
            end else begin
               valid_in = 1'b0;
            end
         end
         ready_in = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = valid_in && ready_a;
         step();
         if (acc) begin
            pending = 1'b0;
            sent++;
         end
      end
      valid_in = 1'b0;
      ready_in = 1'b1;
      repeat (5) step();
      chk("random_sent", sent, 10000);
      chk("random_drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
